pipe_stall_seq: RTL and testbench
=================================

PIPE_STALL_SEQ -- requirements
Module: pipe_stall_seq

Interface
REQ-001 Parameter CNT_W, default 3, width of stall count and remaining-count fields.
REQ-002 Parameter MAX_STALL, default 5, largest legal stall length in cycles; SHALL satisfy 1 <= MAX_STALL <= 2^CNT_W-1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall_req  in  1  hazard unit requests a stall this cycle.
REQ-006 stall_count  in  CNT_W  requested stall length in cycles; sampled only when stall_req=1.
REQ-007 flush  in  1  branch/jump redirect; level; sampled only when ext_hold=0.
REQ-008 ext_hold  in  1  memory/cache hold that freezes the front end.
REQ-009 pause_pc  out  1  1 = PC register holds its value.
REQ-010 wrt_IF_ID  out  1  1 = IF/ID register loads.
REQ-011 bubble_ID_EX  out  1  1 = insert NOP into ID/EX.
REQ-012 flush_IF_ID  out  1  1 = clear IF/ID to NOP.
REQ-013 busy  out  1  1 = multi-cycle stall in progress (state STALL).
REQ-014 remaining  out  CNT_W  stall cycles left after the current cycle.
REQ-015 err  out  1  illegal stall_count seen this cycle.

Function
REQ-016 The block SHALL have two states, IDLE and STALL, plus register rem[CNT_W-1:0].
REQ-017 Outputs SHALL be combinational from state, rem and current inputs (Mealy); there is no added latency.
REQ-018 Stall cycle outputs: pause_pc=1, wrt_IF_ID=0, bubble_ID_EX=1, flush_IF_ID=0.
REQ-019 Run cycle outputs (no stall, no flush, no hold): pause_pc=0, wrt_IF_ID=1, bubble_ID_EX=0, flush_IF_ID=0.
REQ-020 Effective length n SHALL equal stall_count, saturated to MAX_STALL.
REQ-021 err SHALL be 1 exactly when stall_req=1, ext_hold=0, flush=0 and stall_count > MAX_STALL.
REQ-022 IDLE, stall_req=1, n=0: run cycle; the state stays IDLE.
REQ-023 IDLE, stall_req=1, n=1: stall cycle; the state stays IDLE.
REQ-024 IDLE, stall_req=1, n>=2: stall cycle; rem<=n-1; the state goes to STALL. A stall SHALL last exactly n cycles in total.
REQ-025 STALL: stall cycle; rem<=rem-1; the state goes to IDLE when rem==1.
REQ-026 A new stall_req received in STALL SHALL merge: rem<=max(rem-1, n-1); the state stays STALL if the result is nonzero, otherwise IDLE.
REQ-027 When flush=1 and ext_hold=0, the cycle SHALL be a flush cycle in any state:
  - outputs pause_pc=0, wrt_IF_ID=1, flush_IF_ID=1, bubble_ID_EX=1;
  - next state IDLE with rem<=0;
  - stall_req is ignored and err=0.
REQ-028 When ext_hold=1, ext_hold SHALL have highest priority:
  - outputs pause_pc=1, wrt_IF_ID=0, bubble_ID_EX=0, flush_IF_ID=0, err=0;
  - state and rem are frozen; stall_req and flush are ignored.
REQ-029 Upstream SHALL hold flush asserted until a cycle with ext_hold=0.
REQ-030 busy SHALL be 1 iff the state is STALL; remaining SHALL equal rem.

Reset
REQ-031 When rst=1 on a rising edge, the next state SHALL be IDLE with rem=0, regardless of any other input, including mid-stall.
REQ-032 In any cycle with rst=1, the outputs SHALL be: pause_pc=0, wrt_IF_ID=1, bubble_ID_EX=0, flush_IF_ID=0, busy=0, remaining=0, err=0.

Structure
REQ-033 The state encodings (IDLE=1'b0, STALL=1'b1) and the MAX_STALL default SHALL live in the shared pipeline defines include file.
REQ-034 The state bit SHALL use the codebase dff cell.
REQ-035 The rem register with load, decrement and merge logic SHALL be one sub-module, stall_down_cnt, parameterised by CNT_W.

Verification
REQ-036 Reset, then stall_req=1 with count=1 for one cycle -> exactly 1 cycle with pause_pc=1/wrt_IF_ID=0; busy stays 0.
REQ-037 stall_req=1 with count=4 -> 4 consecutive stall cycles; remaining reads 3,2,1 in the STALL cycles; busy=1 for 3 cycles.
REQ-038 stall_req=1 with count=7 (MAX_STALL=5) -> err=1 in that cycle; exactly 5 stall cycles.
REQ-039 count=3 stall; on its second cycle, stall_req=1 with count=4 -> rem becomes 3; total stall length 5 cycles.
REQ-040 count=5 stall; flush=1 on the 2nd cycle -> flush_IF_ID=1, pause_pc=0 that cycle; IDLE with remaining=0 in the next cycle.
REQ-041 count=3 stall; ext_hold=1 for 2 cycles starting on the 2nd stall cycle -> remaining frozen at 2; 5 cycles total with pause_pc=1.
REQ-042 count=4 stall; rst=1 on the 2nd stall cycle -> IDLE with run-cycle outputs in the next cycle.

Source files
------------

// File: rtl/pipe_stall_seq_pkg.sv
// Shared pipeline definitions for the stall sequencer.
// Holds the FSM state encoding, the default maximum stall length and the
// operation codes that steer the remaining-count register.
package pipe_stall_seq_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StStall = 1'b1
  } state_e;

  localparam int unsigned MaxStallDflt = 5;

  typedef enum logic [2:0] {
    RemHold,
    RemClear,
    RemLoad,
    RemDec,
    RemMerge
  } rem_op_e;

endpackage

// File: rtl/pipe_stall_seq_dff.sv
// Generic D flip-flop cell with synchronous active-high reset to zero.
// Ports: clk - clock, rst - synchronous reset, d - next value, q - stored value.
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stall_seq_stall_down_cnt.sv
// Remaining-stall-cycles register with hold, clear, load, decrement and merge.
// Ports: clk, rst (synchronous), op - operation for this cycle, ld_val - value
// to load or merge, rem - current count, rem_nxt - value taken on next edge.
module stall_down_cnt
  import pipe_stall_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  rem_op_e          op,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] rem,
  output logic [CNT_W-1:0] rem_nxt
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [CNT_W-1:0] dec_val;

  // Floor at zero so a stray decrement can never wrap.
  assign dec_val = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);

  always_comb begin
    rem_d = rem_q;
    unique case (op)
      RemHold:  rem_d = rem_q;
      RemClear: rem_d = '0;
      RemLoad:  rem_d = ld_val;
      RemDec:   rem_d = dec_val;
      RemMerge: rem_d = (dec_val > ld_val) ? dec_val : ld_val;
      default:  rem_d = rem_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem     = rem_q;
  assign rem_nxt = rem_d;

endmodule

// File: rtl/pipe_stall_seq.sv
// Pipeline stall sequencer: turns hazard stall requests of a given length into
// per-cycle PC/IF-ID/ID-EX control, with flush and external hold overrides.
// Ports: clk, rst (sync, active high), stall_req, stall_count, flush, ext_hold;
// outputs pause_pc, wrt_IF_ID, bubble_ID_EX, flush_IF_ID, busy, remaining, err.
// Outputs are Mealy: combinational from state, rem and the current inputs.
module pipe_stall_seq
  import pipe_stall_seq_pkg::*;
#(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned MAX_STALL = MaxStallDflt
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic [CNT_W-1:0] stall_count,
  input  logic             flush,
  input  logic             ext_hold,
  output logic             pause_pc,
  output logic             wrt_IF_ID,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             err
);

  localparam logic [CNT_W-1:0] MaxN = CNT_W'(MAX_STALL);

  logic             state_bit_q;
  logic             state_bit_d;
  state_e           state_q;
  logic             too_long;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_nxt;
  rem_op_e          rem_op;

  assign state_q  = state_e'(state_bit_q);
  assign too_long = stall_count > MaxN;
  assign n_eff    = too_long ? MaxN : stall_count;
  // Cycles still owed after this one; zero for n=0 and n=1.
  assign ld_val   = (n_eff == '0) ? '0 : n_eff - CNT_W'(1);

  always_comb begin
    pause_pc     = 1'b0;
    wrt_IF_ID    = 1'b1;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    err          = 1'b0;
    rem_op       = RemHold;
    if (rst) begin
      // Run-cycle outputs; both registers clear through their own reset.
      rem_op = RemHold;
    end else if (ext_hold) begin
      pause_pc  = 1'b1;
      wrt_IF_ID = 1'b0;
    end else if (flush) begin
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
      rem_op       = RemClear;
    end else begin
      err = stall_req && too_long;
      if (state_q == StStall) begin
        pause_pc     = 1'b1;
        wrt_IF_ID    = 1'b0;
        bubble_ID_EX = 1'b1;
        rem_op       = stall_req ? RemMerge : RemDec;
      end else if (stall_req && (n_eff != '0)) begin
        pause_pc     = 1'b1;
        wrt_IF_ID    = 1'b0;
        bubble_ID_EX = 1'b1;
        rem_op       = RemLoad;
      end
    end
  end

  // STALL is exactly "cycles still owed"; under hold rem_nxt equals rem, which
  // already agrees with the frozen state, so the state needs no extra case.
  assign state_bit_d = (rem_nxt != '0);

  dff #(
    .W(1)
  ) u_state_dff (
    .clk(clk),
    .rst(rst),
    .d  (state_bit_d),
    .q  (state_bit_q)
  );

  stall_down_cnt #(
    .CNT_W(CNT_W)
  ) u_rem_cnt (
    .clk    (clk),
    .rst    (rst),
    .op     (rem_op),
    .ld_val (ld_val),
    .rem    (rem_q),
    .rem_nxt(rem_nxt)
  );

  assign busy      = !rst && (state_q == StStall);
  assign remaining = rst ? '0 : rem_q;

endmodule

// File: tb/tb_pipe_stall_seq.sv
// Self-checking bench for pipe_stall_seq: directed scenarios then random
// stimulus, checked against a cycle-count reference model via a scoreboard.
module tb_pipe_stall_seq;

  localparam int CntW     = 3;
  localparam int MaxStall = 5;

  typedef struct packed {
    logic            pause;
    logic            wrt;
    logic            bubble;
    logic            fl;
    logic            busy;
    logic [CntW-1:0] rem;
    logic            err;
  } out_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall_req = 1'b0;
  logic [CntW-1:0] stall_count = '0;
  logic            flush = 1'b0;
  logic            ext_hold = 1'b0;
  logic            pause_pc;
  logic            wrt_IF_ID;
  logic            bubble_ID_EX;
  logic            flush_IF_ID;
  logic            busy;
  logic [CntW-1:0] remaining;
  logic            err;

  pipe_stall_seq #(
    .CNT_W    (CntW),
    .MAX_STALL(MaxStall)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_req   (stall_req),
    .stall_count (stall_count),
    .flush       (flush),
    .ext_hold    (ext_hold),
    .pause_pc    (pause_pc),
    .wrt_IF_ID   (wrt_IF_ID),
    .bubble_ID_EX(bubble_ID_EX),
    .flush_IF_ID (flush_IF_ID),
    .busy        (busy),
    .remaining   (remaining),
    .err         (err)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   cyc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   pend  = 0;  // stall cycles still owed after the current cycle

  // Reference: one integer of owed stall cycles, updated by the stated rules.
  task automatic step(input bit r, input bit h, input bit f, input bit req, input int cnt);
    out_t e;
    int   n;
    int   nxt;
    @(posedge clk);
    #1;
    rst         = r;
    ext_hold    = h;
    flush       = f;
    stall_req   = req;
    stall_count = CntW'(cnt);
    e      = '0;
    e.busy = (pend > 0);
    e.rem  = CntW'(pend);
    if (r) begin
      e     = '0;
      e.wrt = 1'b1;
      pend  = 0;
    end else if (h) begin
      e.pause = 1'b1;
    end else if (f) begin
      e.wrt    = 1'b1;
      e.fl     = 1'b1;
      e.bubble = 1'b1;
      pend     = 0;
    end else begin
      n     = (cnt > MaxStall) ? MaxStall : cnt;
      e.err = req && (cnt > MaxStall);
      if (pend > 0 || (req && n > 0)) begin
        e.pause  = 1'b1;
        e.bubble = 1'b1;
      end else begin
        e.wrt = 1'b1;
      end
      nxt = (pend > 0) ? pend - 1 : 0;
      if (req && n - 1 > nxt) nxt = n - 1;
      pend = nxt;
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle presents a result, checked mid-cycle on the falling edge.
  always @(negedge clk) begin
    out_t got;
    out_t e;
    int   c;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      c   = cyc_q.pop_front();
      got = '{pause_pc, wrt_IF_ID, bubble_ID_EX, flush_IF_ID, busy, remaining, err};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outs cycle %0d pause/wrt/bub/flush/busy/rem/err got=%b/%b/%b/%b/%b/%0d/%b want=%b/%b/%b/%b/%b/%0d/%b",
                 c, got.pause, got.wrt, got.bubble, got.fl, got.busy, got.rem, got.err,
                 e.pause, e.wrt, e.bubble, e.fl, e.busy, e.rem, e.err);
      end
    end
  end

  initial begin
    int wait_cnt;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 4);
    // Single-cycle stall
    step(0, 0, 0, 1, 1); idle(3);
    // Four-cycle stall
    step(0, 0, 0, 1, 4); idle(5);
    // Over-long request saturates
    step(0, 0, 0, 1, 7); idle(6);
    // Merge on second cycle
    step(0, 0, 0, 1, 3); step(0, 0, 0, 1, 4); idle(6);
    // Flush mid-stall
    step(0, 0, 0, 1, 5); step(0, 0, 1, 1, 7); idle(3);
    // External hold mid-stall
    step(0, 0, 0, 1, 3); step(0, 1, 1, 1, 7); step(0, 1, 0, 0, 0); idle(4);
    // Reset mid-stall
    step(0, 0, 0, 1, 4); step(1, 0, 0, 0, 0); idle(3);
    // Zero-length request and err suppressed under flush
    step(0, 0, 0, 1, 0); step(0, 0, 1, 1, 7); idle(2);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 7)));
    end
    idle(1);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
